// File: rtl/bcd_parse_if.sv
// Byte-in / BCD-out bundle between the UART receiver, bcd_parse and its consumer.
// The master side supplies bytes and the slave side (bcd_parse) returns parsed values.
interface bcd_parse_if #(
  parameter int DIGITS = 3
) ();
  logic [7:0]          data_in;
  logic                data_in_en;
  logic [4*DIGITS-1:0] bcd_out;
  logic                bcd_out_en;
  logic                err_out;

  modport master (
    output data_in, data_in_en,
    input  bcd_out, bcd_out_en, err_out
  );

  modport slave (
    input  data_in, data_in_en,
    output bcd_out, bcd_out_en, err_out
  );
endinterface

// File: rtl/bcd_parse.sv
// Assembles a CR/LF-terminated line of ASCII decimal digits into a packed BCD word.
// Rejects malformed, over-length and stalled lines with a one-cycle error strobe.
module bcd_parse #(
   parameter int DIGITS         = 3,
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input logic         sys_clk,
   input logic         sys_rst,
   bcd_parse_if.slave  bus
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CW    = $clog2(DIGITS + 1);
   localparam int TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CW-1:0] CNT_MAX  = CW'(DIGITS);

   typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CW-1:0]    count;
   logic [TW-1:0]    tmo_cnt;

   logic       is_digit;
   logic       is_term;
   logic [3:0] nibble;
   logic       tmo_hit;

   always_comb begin
      is_digit = (bus.data_in >= 8'h30) && (bus.data_in <= 8'h39);
      is_term  = (bus.data_in == 8'h0D) || (bus.data_in == 8'h0A);
      nibble   = bus.data_in[3:0];
      tmo_hit  = (TIMEOUT_CYCLES > 0) && (tmo_cnt == TMO_LAST);
   end

   // NOTE: every register here is sequential state, so only non-blocking assignments are used.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state          <= IDLE;
         acc            <= '0;
         count          <= '0;
         tmo_cnt        <= '0;
         bus.bcd_out    <= '0;
         bus.bcd_out_en <= 1'b0;
         bus.err_out    <= 1'b0;
      end else begin
         bus.bcd_out_en <= 1'b0;
         bus.err_out    <= 1'b0;

         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (bus.data_in_en) begin
                  if (is_digit) begin
                     acc   <= ACC_W'(nibble);
                     count <= CW'(1);
                     state <= COLLECT;
                  end else if (!is_term) begin
                     bus.err_out <= 1'b1;
                     state       <= DISCARD;
                  end
               end
            end

            COLLECT: begin
               if (bus.data_in_en) begin
                  tmo_cnt <= '0;
                  if (is_digit && count != CNT_MAX) begin
                     acc   <= (acc << 4) | ACC_W'(nibble);
                     count <= count + CW'(1);
                  end else if (is_term) begin
                     bus.bcd_out    <= acc;
                     bus.bcd_out_en <= 1'b1;
                     acc            <= '0;
                     count          <= '0;
                     state          <= IDLE;
                  end else begin
                     // Over-length digit or invalid byte: reject the rest of the line.
                     bus.err_out <= 1'b1;
                     acc         <= '0;
                     count       <= '0;
                     state       <= DISCARD;
                  end
               end else if (tmo_hit) begin
                  bus.err_out <= 1'b1;
                  acc         <= '0;
                  count       <= '0;
                  tmo_cnt     <= '0;
                  state       <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end

            DISCARD: begin
               if (bus.data_in_en) begin
                  tmo_cnt <= '0;
                  if (is_term) state <= IDLE;
               end else if (tmo_hit) begin
                  tmo_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end

            default: begin
               acc     <= '0;
               count   <= '0;
               tmo_cnt <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
